// File: rtl/seg_display_pkg.sv
// Shared definitions for the multiplexed seven-segment display controller:
// glyph table, configuration record layout and size limits.
package seg_display_pkg;

    // Largest digit count and brightness resolution the configuration record can hold.
    localparam int MAX_DIGITS      = 16;
    localparam int MAX_BRIGHT_BITS = 16;

    // Active-high segment patterns {g,f,e,d,c,b,a} for hex values 0..F.
    localparam logic [6:0] GLYPH_TABLE [16] = '{
        7'h3F, 7'h06, 7'h5B, 7'h4F,
        7'h66, 7'h6D, 7'h7D, 7'h07,
        7'h7F, 7'h6F, 7'h77, 7'h7C,
        7'h39, 7'h5E, 7'h79, 7'h71
    };

    // One complete display configuration, sized for the largest legal display.
    // Unused upper digits and brightness bits are held at zero.
    typedef struct packed {
        logic [4*MAX_DIGITS-1:0]    val;
        logic [MAX_DIGITS-1:0]      dp;
        logic [MAX_DIGITS-1:0]      blank;
        logic                       lz_en;
        logic [MAX_BRIGHT_BITS-1:0] bright;
    } disp_cfg_t;

    // Active-high segment pattern for one hex nibble.
    function automatic logic [6:0] glyph_lookup(input logic [3:0] nib);
        return GLYPH_TABLE[nib];
    endfunction

endpackage

// File: rtl/seg_display_ctrl_if.sv
// Configuration load bus of the display controller: per-digit data and
// attributes qualified by load_in, with load_ready_out as back-pressure.
interface seg_display_ctrl_if #(
    parameter int NUM_DIGITS  = 8,
    parameter int BRIGHT_BITS = 4
);
    logic [4*NUM_DIGITS-1:0] val_in;
    logic [NUM_DIGITS-1:0]   dp_in;
    logic [NUM_DIGITS-1:0]   blank_in;
    logic                    lz_en_in;
    logic [BRIGHT_BITS-1:0]  bright_in;
    logic                    load_in;
    logic                    load_ready_out;

    // Side that supplies configurations.
    modport master (
        output val_in, dp_in, blank_in, lz_en_in, bright_in, load_in,
        input  load_ready_out
    );

    // Display controller side.
    modport slave (
        input  val_in, dp_in, blank_in, lz_en_in, bright_in, load_in,
        output load_ready_out
    );
endinterface

// File: rtl/seg_display_ctrl_hex_to_seg.sv
// Combinational hex nibble to active-high seven-segment pattern.
module hex_to_seg
    import seg_display_pkg::*;
(
    input  logic [3:0] nib_in,
    output logic [6:0] seg_out
);

    // Pure table lookup.
    always_comb begin
        seg_out = glyph_lookup(nib_in);
    end

endmodule

// File: rtl/seg_display_ctrl.sv
// Multiplexed seven-segment display controller. Scans NUM_DIGITS digits,
// each selected for DIGIT_PERIOD cycles, with PWM brightness, leading-zero
// suppression, per-digit blanking and decimal points. New configurations
// are staged in a one-entry pending buffer and only become active at a
// frame boundary so a frame is never drawn with mixed data.
module seg_display_ctrl
    import seg_display_pkg::*;
#(
    parameter int NUM_DIGITS   = 8,
    parameter int DIGIT_PERIOD = 100_000,
    parameter int BRIGHT_BITS  = 4
) (
    input  logic                  clk_in,
    input  logic                  rst_in,
    seg_display_ctrl_if.slave     cfg_if,
    output logic [6:0]            cat_out,
    output logic                  dp_out,
    output logic [NUM_DIGITS-1:0] an_out,
    output logic                  frame_out
);

    localparam int CNT_W = (DIGIT_PERIOD > 1) ? $clog2(DIGIT_PERIOD) : 1;
    localparam int IDX_W = (NUM_DIGITS > 1) ? $clog2(NUM_DIGITS) : 1;
    localparam int STEP  = DIGIT_PERIOD / (2 ** BRIGHT_BITS);

    localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(DIGIT_PERIOD - 1);
    localparam logic [IDX_W-1:0] IDX_LAST = IDX_W'(NUM_DIGITS - 1);

    // Power-on configuration: everything zero, full brightness.
    localparam disp_cfg_t ACT_RST = '{
        val:    '0,
        dp:     '0,
        blank:  '0,
        lz_en:  1'b0,
        bright: MAX_BRIGHT_BITS'((1 << BRIGHT_BITS) - 1)
    };

    // Scan state
    logic [CNT_W-1:0] cnt_q, cnt_d;
    logic [IDX_W-1:0] idx_q, idx_d;
    logic             run_q, run_d;
    logic             bnd_q, bnd_d;

    // Configuration staging
    logic             pend_full_q, pend_full_d;
    disp_cfg_t        pend_q, pend_d;
    disp_cfg_t        act_q, act_d;

    // Registered display outputs
    logic [6:0]            cat_q, cat_d;
    logic                  dp_q, dp_d;
    logic [NUM_DIGITS-1:0] an_q, an_d;
    logic                  frame_q, frame_d;

    // Combinational helpers
    logic                  boundary;
    logic                  load_acc;
    logic [3:0]            idx4;
    logic [3:0]            seg_nib;
    logic [6:0]            glyph;
    logic [MAX_DIGITS-1:0] zero_run;
    logic                  digit_blank;
    logic                  duty_on;
    logic [47:0]           duty_thr;

    assign idx4     = 4'(idx_q);
    assign boundary = run_q && (cnt_q == CNT_LAST) && (idx_q == IDX_LAST);
    assign load_acc = cfg_if.load_in && !pend_full_q;
    assign seg_nib  = act_q.val[{idx4, 2'b00} +: 4];

    assign cfg_if.load_ready_out = ~pend_full_q;
    assign cat_out   = cat_q;
    assign dp_out    = dp_q;
    assign an_out    = an_q;
    assign frame_out = frame_q;

    hex_to_seg u_hex_to_seg (
        .nib_in  (seg_nib),
        .seg_out (glyph)
    );

    // zero_run[k] is set when digit k and every digit above it are zero.
    always_comb begin
        logic all_zero;
        all_zero = 1'b1;
        zero_run = '0;
        for (int k = MAX_DIGITS - 1; k >= 0; k--) begin
            all_zero    = all_zero && (act_q.val[4*k +: 4] == 4'h0);
            zero_run[k] = all_zero;
        end
    end

    // Per-digit blanking and PWM window for the currently selected digit.
    always_comb begin
        digit_blank = act_q.blank[idx4] ||
                      (act_q.lz_en && (idx_q != '0) && zero_run[idx4]);
        duty_thr    = (48'(act_q.bright) + 48'd1) * 48'(STEP);
        duty_on     = 48'(cnt_q) < duty_thr;
    end

    // Dwell counter and digit index; both hold for one cycle after reset release.
    always_comb begin
        cnt_d = cnt_q;
        idx_d = idx_q;
        run_d = 1'b1;
        bnd_d = boundary;
        if (run_q) begin
            if (cnt_q == CNT_LAST) begin
                cnt_d = '0;
                idx_d = (idx_q == IDX_LAST) ? '0 : idx_q + 1'b1;
            end else begin
                cnt_d = cnt_q + 1'b1;
            end
        end
    end

    // Load handshake and pending-to-active transfer at the frame boundary.
    always_comb begin
        pend_d      = pend_q;
        pend_full_d = pend_full_q;
        act_d       = act_q;
        if (boundary && pend_full_q) begin
            act_d       = pend_q;
            pend_full_d = 1'b0;
        end
        if (load_acc) begin
            pend_d                               = '0;
            pend_d.val[4*NUM_DIGITS-1:0]         = cfg_if.val_in;
            pend_d.dp[NUM_DIGITS-1:0]            = cfg_if.dp_in;
            pend_d.blank[NUM_DIGITS-1:0]         = cfg_if.blank_in;
            pend_d.lz_en                         = cfg_if.lz_en_in;
            pend_d.bright[BRIGHT_BITS-1:0]       = cfg_if.bright_in;
            pend_full_d                          = 1'b1;
        end
    end

    // Output decode for the selected digit; frame pulse trails the boundary
    // so it lines up with digit 0 appearing on the outputs.
    always_comb begin
        cat_d   = '1;
        dp_d    = 1'b1;
        an_d    = '1;
        frame_d = bnd_q;
        if (run_q) begin
            if (!digit_blank) begin
                cat_d = ~glyph;
                dp_d  = ~act_q.dp[idx4];
            end
            if (duty_on) begin
                an_d = ~(NUM_DIGITS'(1) << idx_q);
            end
        end
    end

    // State and output registers.
    always_ff @(posedge clk_in or posedge rst_in) begin
        if (rst_in) begin
            cnt_q       <= '0;
            idx_q       <= '0;
            run_q       <= 1'b0;
            bnd_q       <= 1'b0;
            pend_full_q <= 1'b0;
            pend_q      <= '0;
            act_q       <= ACT_RST;
            cat_q       <= '1;
            dp_q        <= 1'b1;
            an_q        <= '1;
            frame_q     <= 1'b0;
        end else begin
            cnt_q       <= cnt_d;
            idx_q       <= idx_d;
            run_q       <= run_d;
            bnd_q       <= bnd_d;
            pend_full_q <= pend_full_d;
            pend_q      <= pend_d;
            act_q       <= act_d;
            cat_q       <= cat_d;
            dp_q        <= dp_d;
            an_q        <= an_d;
            frame_q     <= frame_d;
        end
    end

endmodule

// File: tb/tb_seg_display_ctrl.sv
// Scoreboard bench for seg_display_ctrl (4 digits, 8-cycle dwell, 2-bit brightness).
module tb_seg_display_ctrl;

    typedef struct packed {
        logic [15:0] val;
        logic [3:0]  dp;
        logic [3:0]  blank;
        logic        lz;
        logic [1:0]  bright;
    } tcfg_t;

    typedef struct packed {
        logic [6:0] cat;
        logic       dp;
        logic [3:0] an;
        logic       frame;
        logic       rdy;
    } exp_t;

    // Active-low glyphs {g,f,e,d,c,b,a} for 0..F.
    localparam logic [6:0] GLY [16] = '{
        7'h40, 7'h79, 7'h24, 7'h30, 7'h19, 7'h12, 7'h02, 7'h78,
        7'h00, 7'h10, 7'h08, 7'h03, 7'h46, 7'h21, 7'h06, 7'h0E
    };

    logic       clk_in = 1'b0;
    logic       rst_in = 1'b0;
    logic [6:0] cat_out;
    logic       dp_out;
    logic [3:0] an_out;
    logic       frame_out;

    seg_display_ctrl_if #(.NUM_DIGITS(4), .BRIGHT_BITS(2)) cfg_if ();

    seg_display_ctrl #(
        .NUM_DIGITS   (4),
        .DIGIT_PERIOD (8),
        .BRIGHT_BITS  (2)
    ) dut (
        .clk_in    (clk_in),
        .rst_in    (rst_in),
        .cfg_if    (cfg_if),
        .cat_out   (cat_out),
        .dp_out    (dp_out),
        .an_out    (an_out),
        .frame_out (frame_out)
    );

    always #5 clk_in = ~clk_in;

    int    checks   = 0;
    int    failures = 0;
    int    e        = 0;
    bit    started  = 0;
    bit    m_pend   = 0;
    tcfg_t m_pcfg;
    tcfg_t m_act;
    exp_t  exp_q [$];

    localparam tcfg_t RST_CFG = '{val: 16'h0, dp: 4'h0, blank: 4'h0, lz: 1'b0, bright: 2'd3};

    // Expected outputs e edges after reset release, drawn from configuration c.
    function automatic exp_t model_out(int ee, tcfg_t c);
        exp_t x;
        int s, d, w;
        logic [3:0] nib;
        bit blk;
        x = '{cat: 7'h7F, dp: 1'b1, an: 4'hF, frame: 1'b0, rdy: 1'b1};
        if (ee >= 2) begin
            s   = ee - 2;
            d   = (s / 8) % 4;
            w   = s % 8;
            nib = c.val[4*d +: 4];
            blk = c.blank[d] || (c.lz && d > 0 && (c.val >> (4 * d)) == 16'h0);
            if (!blk) begin
                x.cat = GLY[nib];
                x.dp  = ~c.dp[d];
            end
            if (w < (int'(c.bright) + 1) * 2) x.an = ~(4'b0001 << d);
            x.frame = (s > 0) && (s % 32 == 0);
        end
        return x;
    endfunction

    task automatic check(input string name, input logic [7:0] got, input logic [7:0] want);
        checks++;
        if (got !== want) begin
            failures++;
            $display("FAIL %s t=%0t got=%h expected=%h", name, $time, got, want);
        end
    endtask

    // Monitor: every clock edge (and reset assertion) presents a new output set.
    initial begin
        exp_t x;
        forever begin
            @(posedge clk_in or posedge rst_in);
            #1;
            if (exp_q.size() == 0) begin
                if (started) check("scoreboard_underflow", 8'd0, 8'd1);
            end else begin
                x = exp_q.pop_front();
                check("cat_out",        {1'b0, cat_out},            {1'b0, x.cat});
                check("dp_out",         {7'b0, dp_out},             {7'b0, x.dp});
                check("an_out",         {4'b0, an_out},             {4'b0, x.an});
                check("frame_out",      {7'b0, frame_out},          {7'b0, x.frame});
                check("load_ready_out", {7'b0, cfg_if.load_ready_out}, {7'b0, x.rdy});
            end
        end
    end

    // One stimulus cycle: drive at the falling edge, predict the next rising edge.
    task automatic cyc(input bit rst_v, input bit ld, input tcfg_t c);
        exp_t x;
        bit acc;
        @(negedge clk_in);
        started = 1;
        if (rst_v && !rst_in) begin
            m_pend = 0;
            m_act  = RST_CFG;
            exp_q.push_back(model_out(0, m_act));
        end
        rst_in             = rst_v;
        cfg_if.load_in     = ld;
        cfg_if.val_in      = c.val;
        cfg_if.dp_in       = c.dp;
        cfg_if.blank_in    = c.blank;
        cfg_if.lz_en_in    = c.lz;
        cfg_if.bright_in   = c.bright;
        if (rst_v) begin
            e      = 0;
            m_pend = 0;
            m_act  = RST_CFG;
            exp_q.push_back(model_out(0, m_act));
        end else begin
            e++;
            x   = model_out(e, m_act);
            acc = ld && !m_pend;
            if (e >= 2 && (e - 2) % 32 == 31 && m_pend) begin
                m_act  = m_pcfg;
                m_pend = 0;
            end
            if (acc) begin
                m_pcfg = c;
                m_pend = 1;
            end
            x.rdy = !m_pend;
            exp_q.push_back(x);
        end
    endtask

    function automatic tcfg_t mk(logic [15:0] v, logic [3:0] dp, logic [3:0] bl, logic lz, logic [1:0] br);
        tcfg_t c;
        c = '{val: v, dp: dp, blank: bl, lz: lz, bright: br};
        return c;
    endfunction

    function automatic tcfg_t rnd_cfg();
        tcfg_t c;
        c.val    = 16'($urandom);
        c.dp     = 4'($urandom);
        c.blank  = ($urandom_range(0, 3) == 0) ? 4'($urandom) : 4'h0;
        c.lz     = 1'($urandom);
        c.bright = 2'($urandom);
        if ($urandom_range(0, 3) == 0) c.val = c.val & 16'h00FF;
        return c;
    endfunction

    initial begin
        tcfg_t z;
        z = '0;
        cfg_if.load_in = 1'b0;
        m_act = RST_CFG;
        m_pcfg = '0;

        repeat (3) cyc(1, 0, z);

        // Scan with 12A8 at full brightness.
        cyc(0, 1, mk(16'h12A8, 4'h0, 4'h0, 1'b0, 2'd3));
        repeat (110) cyc(0, 0, z);

        // Leading-zero suppression on and off.
        cyc(0, 1, mk(16'h0030, 4'h0, 4'h0, 1'b1, 2'd3));
        repeat (70) cyc(0, 0, z);
        cyc(0, 1, mk(16'h0030, 4'h0, 4'h0, 1'b0, 2'd3));
        repeat (70) cyc(0, 0, z);

        // Back-to-back loads mid-frame: only the first is taken.
        repeat (5) cyc(0, 0, z);
        cyc(0, 1, mk(16'h4321, 4'h0, 4'h0, 1'b0, 2'd3));
        cyc(0, 1, mk(16'hABCD, 4'hF, 4'h0, 1'b0, 2'd0));
        repeat (70) cyc(0, 0, z);

        // Reduced brightness levels.
        cyc(0, 1, mk(16'h5678, 4'h0, 4'h0, 1'b0, 2'd1));
        repeat (70) cyc(0, 0, z);
        cyc(0, 1, mk(16'h9EF0, 4'h0, 4'h0, 1'b0, 2'd0));
        repeat (70) cyc(0, 0, z);

        // Blanking and decimal points.
        cyc(0, 1, mk(16'h7777, 4'b0101, 4'b0100, 1'b0, 2'd3));
        repeat (70) cyc(0, 0, z);

        // Random configurations and load strobes.
        for (int i = 0; i < 600; i++) begin
            cyc(0, ($urandom_range(0, 9) == 0), rnd_cfg());
        end

        // Reset mid-frame with a load pending; pending data must vanish.
        repeat (40) cyc(0, 0, z);
        repeat (7) cyc(0, 0, z);
        cyc(0, 1, mk(16'hFEDC, 4'hF, 4'h0, 1'b0, 2'd2));
        repeat (3) cyc(0, 0, z);
        repeat (2) cyc(1, 0, z);
        repeat (80) cyc(0, 0, z);

        @(posedge clk_in);
        #2;
        check("scoreboard_drained", 8'(exp_q.size()), 8'd0);
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
